shift_alu_seq: RTL and testbench

//  Sequential shift-then-ALU unit: captures A, B, shift amount/direction and ALU op via valid/ready,

---
 rtl/shift_alu_pkg.sv | 32 +++
 rtl/shift_alu_core.sv | 63 ++++++
 rtl/shift_alu_seq.sv | 153 +++++++++++++++
 tb/tb_shift_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_alu_pkg.sv
// Shared types and constants for the sequential shift-then-ALU unit.
// The optional rotate-right mode is enabled with the SHIFT_ALU_ROR_EN macro.
package shift_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shdir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/shift_alu_core.sv
// Combinational ALU with NZCV flags, applied to the already-shifted operand sa.
// Logic ops pass the shift carry sc through as C; undefined opcodes give zero with only Z set.
module shift_alu_core
  import shift_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             sc,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic           carry;
  logic           ovf;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    flags = '0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, sa} + {1'b0, b};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (sa[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != sa[WIDTH-1]);
      end
      ALU_SUB: begin
        // C=1 means no borrow.
        sum   = {1'b0, sa} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (sa[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != sa[WIDTH-1]);
      end
      ALU_AND: begin
        res   = sa & b;
        carry = sc;
      end
      ALU_OR: begin
        res   = sa | b;
        carry = sc;
      end
      ALU_XOR: begin
        res   = sa ^ b;
        carry = sc;
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/shift_alu_seq.sv
// Multi-cycle shift-then-ALU unit: accept via valid/ready, shift A one bit per cycle, run the ALU,
// hold result/flags until taken. Define SHIFT_ALU_ROR_EN to make shdir=11 rotate instead of LSR.
module shift_alu_seq
  import shift_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       shdir,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic             busy,
  output state_e           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid only in DONE, so no accept coincides with out_ready.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  shdir_e           dir_q, dir_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sc_q, sc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [SHW-1:0]   shamt_sat;
  logic [WIDTH-1:0] sa_step;
  logic             sc_step;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_fl;

  assign shamt_sat = (shamt > SHW'(WIDTH)) ? SHW'(WIDTH) : shamt;

  // One-bit step of the selected shift; sc_step is the bit leaving the register.
  always_comb begin
    sa_step = sa_q;
    sc_step = 1'b0;
    case (dir_q)
      SH_LSL: begin
        sa_step = {sa_q[WIDTH-2:0], 1'b0};
        sc_step = sa_q[WIDTH-1];
      end
      SH_ASR: begin
        sa_step = {sa_q[WIDTH-1], sa_q[WIDTH-1:1]};
        sc_step = sa_q[0];
      end
`ifdef SHIFT_ALU_ROR_EN
      SH_ROR: begin
        sa_step = {sa_q[0], sa_q[WIDTH-1:1]};
        sc_step = sa_q[0];
      end
`endif
      default: begin
        sa_step = {1'b0, sa_q[WIDTH-1:1]};
        sc_step = sa_q[0];
      end
    endcase
  end

  shift_alu_core #(.WIDTH(WIDTH)) u_core (
    .sa    (sa_q),
    .b     (b_q),
    .op    (op_q),
    .sc    (sc_q),
    .res   (alu_res),
    .flags (alu_fl)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    b_d      = b_q;
    op_d     = op_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          b_d     = b;
          op_d    = alu_control;
          dir_d   = shdir_e'(shdir);
          cnt_d   = shamt_sat;
          sc_d    = 1'b0;
          state_d = (shamt_sat == '0) ? ST_EXEC : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sa_d  = sa_step;
        sc_d  = sc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_res;
        flags_d  = alu_fl;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      dir_q    <= SH_LSL;
      cnt_q    <= '0;
      sc_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      sc_q     <= sc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_EXEC);
  assign result      = result_q;
  assign alu_flags   = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_alu_seq.sv
// Directed bench for shift_alu_seq at WIDTH=8: latency, results, flags, back-pressure and reset abort.
module tb_shift_alu_seq;
  import shift_alu_pkg::*;

  localparam int W   = 8;
  localparam int SHW = $clog2(W) + 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [SHW-1:0] shamt;
  logic [1:0]     shdir;
  logic [2:0]     alu_control;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic [3:0]     alu_flags;
  logic           busy;
  state_e         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];

  shift_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .shamt       (shamt),
    .shdir       (shdir),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .alu_flags   (alu_flags),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [SHW-1:0] tsh, input logic [1:0] tdir,
                           input logic [2:0] top);
    a           = ta;
    b           = tb_v;
    shamt       = tsh;
    shdir       = tdir;
    alu_control = top;
    in_valid    = 1'b1;
  endtask

  // Counts rising edges from the handshake edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  // Scoreboard side: compare the held output against the oldest expectation.
  task automatic score(input string tag);
    logic [W+3:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_res"}, 32'(result), 32'(e[W-1:0]));
      check({tag, "_flags"}, 32'(alu_flags), 32'(e[W+3:W]));
    end
  endtask

  // Full transaction from IDLE: issue, check latency and output, then take the result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [SHW-1:0] tsh, input logic [1:0] tdir, input logic [2:0] top,
                        input logic [W-1:0] er, input logic [3:0] ef, input int elat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back({ef, er});
    drive_req(ta, tb_v, tsh, tdir, top);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = ~ta;
    wait_done(lat);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    score(tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  int lat2;
  int seen_valid;

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; shamt = '0; shdir = '0; alu_control = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(alu_flags), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    run_op("t1_lsl_and", 8'h81, 8'hFF, 4'd1, 2'b00, 3'b010, 8'h02, 4'b0010, 3);
    run_op("t2_sub",     8'h7F, 8'hFF, 4'd0, 2'b00, 3'b001, 8'h80, 4'b1001, 2);
    run_op("t3_asr_or",  8'h80, 8'h00, 4'd3, 2'b10, 3'b011, 8'hF0, 4'b1000, 5);
    run_op("t6_lsr_sat", 8'hFF, 8'h00, 4'd9, 2'b01, 3'b000, 8'h00, 4'b0100, 10);
    run_op("t_illegal",  8'h12, 8'h34, 4'd0, 2'b00, 3'b101, 8'h00, 4'b0100, 2);
    run_op("t_lsl8_xor", 8'h01, 8'h00, 4'd8, 2'b00, 3'b100, 8'h00, 4'b0110, 10);
    run_op("t_add_cv",   8'h80, 8'h80, 4'd0, 2'b00, 3'b000, 8'h00, 4'b0111, 2);
`ifdef SHIFT_ALU_ROR_EN
    run_op("t_ror1",     8'h81, 8'h00, 4'd1, 2'b11, 3'b100, 8'hC0, 4'b1010, 3);
    run_op("t_ror8",     8'hA5, 8'h00, 4'd8, 2'b11, 3'b011, 8'hA5, 4'b1010, 10);
`else
    run_op("t_ror_lsr",  8'h81, 8'h00, 4'd1, 2'b11, 3'b100, 8'h40, 4'b0010, 3);
    run_op("t_ror8_lsr", 8'hA5, 8'h00, 4'd8, 2'b11, 3'b011, 8'h00, 4'b0110, 10);
`endif

    // Back-pressure with in_valid held high; the second request uses changed inputs.
    @(negedge clk);
    exp_q.push_back({4'b0010, 8'h02});
    drive_req(8'h81, 8'hFF, 4'd1, 2'b00, 3'b010);
    @(posedge clk);
    #1 drive_req(8'h7F, 8'hFF, 4'd0, 2'b00, 3'b001);
    wait_done(lat2);
    check("t4_latency", 32'(lat2), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check("t4_hold_res", 32'(result), 32'h02);
      check("t4_hold_flags", 32'(alu_flags), 32'b0010);
    end
    score("t4_first");
    exp_q.push_back({4'b1001, 8'h80});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t4_no_same_cycle_accept", 32'(in_ready), 32'd1);
    check("t4_out_dropped", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t4_second_taken_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_second_valid", 32'(out_valid), 32'd1);
    score("t4_second");
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset asserted during the third SHIFT cycle aborts the operation.
    @(negedge clk);
    drive_req(8'h55, 8'h0F, 4'd7, 2'b00, 3'b000);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t5_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
    reset_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("t5_no_result", 32'(seen_valid), 32'd0);
    check("t5_idle_after", 32'(in_ready), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
